kv_stream_feeder: RTL and testbench

//  Front-end feeder for the backend PE. It walks the Q, K and V buffers, and for each query row it

---
 rtl/aura_pkg.sv | 44 ++++
 rtl/kv_prefetch_fifo.sv | 65 ++++++
 rtl/kv_stream_feeder.sv | 218 +++++++++++++++++++++
 tb/tb_kv_stream_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aura_pkg.sv
// -----------------------------------------------------------------------------
// aura_pkg
//   Types and constants shared by the attention front-end blocks.
//   - Q/K/V row vector types, sized by the `MAX_EMBEDDING_DIM define
//   - MAX_SEQ_LEN: row capacity of each Q/K/V buffer
//   - feeder_state_t: kv_stream_feeder FSM encoding
//   - kv_entry_t: one prefetch FIFO entry {k, v, last}
//   - sat_inc32: saturating 32-bit increment used by the optional
//     performance counter (FEEDER_PERF_CNT_EN)
// -----------------------------------------------------------------------------
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

package aura_pkg;

    localparam int MAX_SEQ_LEN = 64;
    localparam int ELEM_W      = 8;
    localparam int VEC_W       = `MAX_EMBEDDING_DIM * ELEM_W;

    typedef logic [VEC_W-1:0] Q_VECTOR_T;
    typedef logic [VEC_W-1:0] K_VECTOR_T;
    typedef logic [VEC_W-1:0] V_VECTOR_T;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Q = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } feeder_state_t;

    typedef struct packed {
        K_VECTOR_T k;
        V_VECTOR_T v;
        logic      last;
    } kv_entry_t;

    // Holds at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/kv_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// kv_prefetch_fifo
//   Two-entry FIFO of {k, v, last} sitting between the K/V buffer read data
//   and the PE handshake. Head entry is presented combinationally.
//   Simultaneous push and pop both take effect (occupancy unchanged). The
//   producer is expected never to push into a full FIFO without a pop.
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset (clears entries and pointers)
//   push       in   write push_data this cycle
//   push_data  in   entry to write
//   pop        in   drop the head entry this cycle (ignored when empty)
//   head       out  current head entry
//   occupancy  out  number of valid entries (0..2)
// -----------------------------------------------------------------------------
module kv_prefetch_fifo
    import aura_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  kv_entry_t  push_data,
    input  logic       pop,
    output kv_entry_t  head,
    output logic [1:0] occupancy
);

    kv_entry_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // When full, a push is only legal because the head slot frees this cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/kv_stream_feeder.sv
// -----------------------------------------------------------------------------
// kv_stream_feeder
//   Producer side of the PE input handshake. For each query row it reads the
//   Q vector once, then streams every K/V row pair through a 2-entry prefetch
//   FIFO toward the PE. K/V reads are credit limited so the FIFO can never
//   overflow while still sustaining one key per cycle when the PE is ready.
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   start, num_rows,         start one pass (sampled in IDLE); row / key
//   num_keys                 counts latched on start
//   busy, done               state != IDLE; 1-cycle completion pulse
//   q_rd_en/addr/data        Q buffer read port (1-cycle read latency)
//   k_rd_en/addr/data        K buffer read port (1-cycle read latency)
//   v_rd_en/addr/data        V buffer read port (same timing/address as K)
//   inputs_valid,            PE handshake; transfer when both high
//   backend_ready
//   q_vector, k_vector,      current query row and FIFO head key/value
//   v_vector
//   kv_last                  head entry is the last key of the row
//   row_idx                  current query row index
//   stall_cycles             (FEEDER_PERF_CNT_EN only) saturating count of
//                            cycles with inputs_valid && !backend_ready,
//                            cleared on start
// Configuration macro: FEEDER_PERF_CNT_EN
// -----------------------------------------------------------------------------
module kv_stream_feeder
    import aura_pkg::*;
#(
    parameter int MAX_SEQ_LEN = aura_pkg::MAX_SEQ_LEN,
    parameter int ADDR_W      = $clog2(MAX_SEQ_LEN),
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_rows,
    input  logic [ADDR_W:0]   num_keys,
    output logic              busy,
    output logic              done,
    output logic              q_rd_en,
    output logic [ADDR_W-1:0] q_rd_addr,
    input  Q_VECTOR_T         q_rd_data,
    output logic              k_rd_en,
    output logic [ADDR_W-1:0] k_rd_addr,
    input  K_VECTOR_T         k_rd_data,
    output logic              v_rd_en,
    output logic [ADDR_W-1:0] v_rd_addr,
    input  V_VECTOR_T         v_rd_data,
    output logic              inputs_valid,
    input  logic              backend_ready,
    output Q_VECTOR_T         q_vector,
    output K_VECTOR_T         k_vector,
    output V_VECTOR_T         v_vector,
    output logic              kv_last,
    output logic [ADDR_W-1:0] row_idx
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    feeder_state_t     state;
    feeder_state_t     state_nxt;
    logic [ADDR_W:0]   rows_r;
    logic [ADDR_W:0]   keys_r;
    logic [ADDR_W-1:0] key_idx;
    logic              inflight;
    logic              inflight_last;
    logic              q_pending;
    logic [1:0]        occ;
    kv_entry_t         head;
    kv_entry_t         push_entry;
    logic              pop;
    logic              issue;
    logic              last_key;
    logic              last_row;
    logic              drain_done;
    logic [2:0]        credit_sum;

    assign pop        = (occ != 2'd0) && backend_ready;
    // Entries already held or on their way, minus the one leaving this cycle.
    assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == STREAM) && (credit_sum < 3'(FIFO_DEPTH));
    assign last_key   = ({1'b0, key_idx} == (keys_r - ONE));
    assign last_row   = ({1'b0, row_idx} == (rows_r - ONE));
    // Leave DRAIN on the cycle the final entry is accepted, so the next row
    // starts with only a 3-cycle bubble.
    assign drain_done = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    // ---- state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((num_rows == '0) || (num_keys == '0)) begin
                        state_nxt = FINISH;
                    end else begin
                        state_nxt = LOAD_Q;
                    end
                end
            end
            LOAD_Q: state_nxt = STREAM;
            STREAM: begin
                if (issue && last_key) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = last_row ? FINISH : LOAD_Q;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- output logic ----
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == FINISH);
        q_rd_en      = (state == LOAD_Q);
        q_rd_addr    = row_idx;
        k_rd_en      = issue;
        v_rd_en      = issue;
        k_rd_addr    = key_idx;
        v_rd_addr    = key_idx;
        inputs_valid = (occ != 2'd0);
        k_vector     = head.k;
        v_vector     = head.v;
        kv_last      = head.last && (occ != 2'd0);
    end

    // ---- counters, Q capture and read tracking ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_r        <= '0;
            keys_r        <= '0;
            key_idx       <= '0;
            row_idx       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            q_pending     <= 1'b0;
            q_vector      <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && last_key;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_r  <= num_rows;
                        keys_r  <= num_keys;
                        row_idx <= '0;
                    end
                end
                LOAD_Q: begin
                    key_idx   <= '0;
                    q_pending <= 1'b1;
                end
                STREAM: begin
                    // Q data returns during the first STREAM cycle; by then the
                    // previous row has fully drained, so q_vector never changes
                    // under a pending transfer.
                    if (q_pending) begin
                        q_vector  <= q_rd_data;
                        q_pending <= 1'b0;
                    end
                    if (issue && !last_key) begin
                        key_idx <= key_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_done && !last_row) begin
                        row_idx <= row_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign push_entry = '{k: k_rd_data, v: v_rd_data, last: inflight_last};

    kv_prefetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

`ifdef FEEDER_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cycles <= '0;
        end else if (inputs_valid && !backend_ready) begin
            stall_cycles <= sat_inc32(stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_kv_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_kv_stream_feeder
//   Scoreboard bench for kv_stream_feeder. Expected transfers are queued when
//   a pass is started and compared as the PE handshake accepts them.
// -----------------------------------------------------------------------------
module tb_kv_stream_feeder;
    import aura_pkg::*;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   num_rows = '0;
    logic [AW:0]   num_keys = '0;
    logic          busy, done;
    logic          q_rd_en, k_rd_en, v_rd_en;
    logic [AW-1:0] q_rd_addr, k_rd_addr, v_rd_addr;
    Q_VECTOR_T     q_rd_data = '0;
    K_VECTOR_T     k_rd_data = '0;
    V_VECTOR_T     v_rd_data = '0;
    logic          inputs_valid;
    logic          backend_ready = 1'b1;
    Q_VECTOR_T     q_vector;
    K_VECTOR_T     k_vector;
    V_VECTOR_T     v_vector;
    logic          kv_last;
    logic [AW-1:0] row_idx;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    kv_stream_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_rows      (num_rows),
        .num_keys      (num_keys),
        .busy          (busy),
        .done          (done),
        .q_rd_en       (q_rd_en),
        .q_rd_addr     (q_rd_addr),
        .q_rd_data     (q_rd_data),
        .k_rd_en       (k_rd_en),
        .k_rd_addr     (k_rd_addr),
        .k_rd_data     (k_rd_data),
        .v_rd_en       (v_rd_en),
        .v_rd_addr     (v_rd_addr),
        .v_rd_data     (v_rd_data),
        .inputs_valid  (inputs_valid),
        .backend_ready (backend_ready),
        .q_vector      (q_vector),
        .k_vector      (k_vector),
        .v_vector      (v_vector),
        .kv_last       (kv_last),
        .row_idx       (row_idx)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Buffer models with 1-cycle read latency.
    Q_VECTOR_T q_mem [64];
    K_VECTOR_T k_mem [64];
    V_VECTOR_T v_mem [64];

    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= q_mem[q_rd_addr];
        if (k_rd_en) k_rd_data <= k_mem[k_rd_addr];
        if (v_rd_en) v_rd_data <= v_mem[v_rd_addr];
    end

    typedef struct {
        int        row;
        Q_VECTOR_T q;
        K_VECTOR_T k;
        V_VECTOR_T v;
        bit        last;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus controls (written only by the main initial block).
    int rows_cur = 0, keys_cur = 0, rdy_mode = 0;
    int iss_base = 0, xfer_base = 0, stall_base = 0;
    bit gap_en = 1'b0, b2b_en = 1'b0;

    // Monitor state (written only by the monitor).
    int cyc = 0;
    int issued_cnt = 0, qrd_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int stall_cnt = 0, valid_cnt = 0;
    int row0_rise_cyc = 0, last_xfer_cyc = 0, last_xfer_row = 0;
    int outst = 0, exp_key = 0, exp_row = 0;
    bit prev_stall = 1'b0, prev_valid = 1'b0;
    Q_VECTOR_T held_q;
    K_VECTOR_T held_k;
    V_VECTOR_T held_v;
    logic      held_last;

    always @(posedge clk) cyc <= cyc + 1;

    // Backend ready policy: 0 = always ready, 1 = toggle, 2 = hold low for
    // the first 10 valid cycles of the pass.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       backend_ready = 1'b1;
            1:       backend_ready = ~backend_ready;
            default: backend_ready = ((stall_cnt - stall_base) >= 10);
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        bit   xfer;
        if (!rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            outst      = 0;
            exp_key    = 0;
            exp_row    = 0;
        end else begin
            xfer = inputs_valid && backend_ready;
            if (done) begin
                done_cnt++;
                chk("done_without_valid", inputs_valid, 0);
            end
            if (inputs_valid) valid_cnt++;
            if (q_rd_en) begin
                qrd_cnt++;
                chk("q_rd_addr", q_rd_addr, exp_row);
                exp_row = (exp_row + 1 == rows_cur) ? 0 : exp_row + 1;
            end
            if (k_rd_en) begin
                issued_cnt++;
                chk("k_rd_addr", k_rd_addr, exp_key);
                chk("v_rd_addr", v_rd_addr, exp_key);
                chk("v_rd_en", v_rd_en, 1);
                exp_key = (exp_key + 1 == keys_cur) ? 0 : exp_key + 1;
            end
            if (inputs_valid && !prev_valid && row_idx == '0) row0_rise_cyc = cyc;
            if (prev_stall) begin
                chk("hold_valid", inputs_valid, 1);
                chk("hold_q", q_vector, held_q);
                chk("hold_k", k_vector, held_k);
                chk("hold_v", v_vector, held_v);
                chk("hold_last", kv_last, held_last);
            end
            outst = outst + (k_rd_en ? 1 : 0) - (xfer ? 1 : 0);
            if (k_rd_en || xfer) chk("outstanding_le_2", outst <= 2, 1);
            if (xfer) begin
                xfer_cnt++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("q_vector", q_vector, e.q);
                    chk("k_vector", k_vector, e.k);
                    chk("v_vector", v_vector, e.v);
                    chk("kv_last", kv_last, e.last);
                    chk("row_idx", row_idx, e.row);
                end
                if (xfer_cnt - xfer_base > 1) begin
                    if (gap_en && int'(row_idx) == last_xfer_row + 1)
                        chk("row_bubble", cyc - last_xfer_cyc, 4);
                    if (b2b_en && int'(row_idx) == last_xfer_row)
                        chk("back_to_back", cyc - last_xfer_cyc, 1);
                end
                last_xfer_cyc = cyc;
                last_xfer_row = int'(row_idx);
            end
            if (inputs_valid && !backend_ready) begin
                stall_cnt++;
                if (rdy_mode == 2 && stall_cnt - stall_base == 10)
                    chk("reads_during_stall", issued_cnt - iss_base, 2);
            end
            prev_stall = inputs_valid && !backend_ready;
            prev_valid = inputs_valid;
            held_q     = q_vector;
            held_k     = k_vector;
            held_v     = v_vector;
            held_last  = kv_last;
        end
    end

    task automatic fill_mems();
        for (int i = 0; i < 64; i++) begin
            q_mem[i] = Q_VECTOR_T'($urandom);
            k_mem[i] = K_VECTOR_T'($urandom);
            v_mem[i] = V_VECTOR_T'($urandom);
        end
    endtask

    task automatic queue_expected(input int rows, input int keys);
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < keys; k++)
                sb.push_back('{row: r, q: q_mem[r], k: k_mem[k], v: v_mem[k], last: (k == keys - 1)});
    endtask

    task automatic check_zero(input string p);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_q_rd_en"}, q_rd_en, 0);
        chk({p, "_k_rd_en"}, k_rd_en, 0);
        chk({p, "_v_rd_en"}, v_rd_en, 0);
        chk({p, "_q_rd_addr"}, q_rd_addr, 0);
        chk({p, "_k_rd_addr"}, k_rd_addr, 0);
        chk({p, "_v_rd_addr"}, v_rd_addr, 0);
        chk({p, "_inputs_valid"}, inputs_valid, 0);
        chk({p, "_q_vector"}, q_vector, 0);
        chk({p, "_kv_last"}, kv_last, 0);
        chk({p, "_row_idx"}, row_idx, 0);
`ifdef FEEDER_PERF_CNT_EN
        chk({p, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    task automatic begin_pass(input int rows, input int keys, input int mode, output int e);
        fill_mems();
        rows_cur   = rows;
        keys_cur   = keys;
        rdy_mode   = mode;
        gap_en     = (mode == 0);
        b2b_en     = (mode != 1);
        iss_base   = issued_cnt;
        xfer_base  = xfer_cnt;
        stall_base = stall_cnt;
        queue_expected(rows, keys);
        @(posedge clk); #1;
        num_rows = (AW + 1)'(rows);
        num_keys = (AW + 1)'(keys);
        start    = 1'b1;
        @(posedge clk); #1;
        e        = cyc;
        start    = 1'b0;
        num_rows = (AW + 1)'($urandom);
        num_keys = (AW + 1)'($urandom);
    endtask

    task automatic run_pass(input int rows, input int keys, input int mode);
        int e, done_base, q_base, v_base;
        bit got;
        done_base = done_cnt;
        q_base    = qrd_cnt;
        v_base    = valid_cnt;
        begin_pass(rows, keys, mode, e);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", got, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - done_base, 1);
        chk("sb_drained", sb.size(), 0);
        chk("kv_reads", issued_cnt - iss_base, rows * keys);
        chk("q_reads", qrd_cnt - q_base, (keys == 0) ? 0 : rows);
        if (rows > 0 && keys > 0) begin
            chk("first_valid_latency", row0_rise_cyc - e, 3);
            chk("transfers", xfer_cnt - xfer_base, rows * keys);
        end else begin
            chk("no_valid", valid_cnt - v_base, 0);
        end
`ifdef FEEDER_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, stall_cnt - stall_base);
        if (mode == 2) chk("stall_cycles_10", stall_cycles, 10);
`endif
        sb.delete();
    endtask

    initial begin
        int e, done_base;
        bit got;

        #12;
        check_zero("reset");
        #8 rst = 1'b1;
        repeat (2) @(posedge clk);

        run_pass(1, 4, 0);
        run_pass(2, 3, 0);
        run_pass(1, 8, 1);
        run_pass(1, 5, 2);
        run_pass(1, 0, 0);
        run_pass(0, 3, 0);
        run_pass(3, 5, 1);

        // Reset in the middle of a row, after an ignored start while busy.
        done_base = done_cnt;
        begin_pass(2, 6, 0, e);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = inputs_valid;
        end
        chk("mid_valid_seen", got, 1);
        @(posedge clk); #1;
        num_rows = (AW + 1)'(1);
        num_keys = (AW + 1)'(1);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        chk("busy_mid_pass", busy, 1);
        chk("row_idx_mid_pass", row_idx, 0);
        #1 rst = 1'b0;
        #1;
        check_zero("async_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", done_cnt - done_base, 0);
        chk("idle_after_rst", busy, 0);
        run_pass(1, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
